// File: rtl/shared_toffoli_seq_if.sv
// ---------------------------------------------------------------------------
// shared_toffoli_seq_if
// Bundles the load, operation, Toffoli-unit and result channels of the
// 2-share masked Toffoli sequencer.
//   slave  : sequencer view (consumes load/op/result-ready, drives tof_*/res_*)
//   master : environment view (masked-permutation top level plus Toffoli unit)
// Share layout of load_data/res_data: share0 of wire i at [i], share1 at
// [NWIRES+i]. On tof_* and tof_a_res, bit 0 is share0 and bit 1 is share1.
// ---------------------------------------------------------------------------
interface shared_toffoli_seq_if #(
  parameter int NWIRES = 8,
  parameter int IDXW   = 3
);
  logic                  load_valid;
  logic                  load_ready;
  logic [2*NWIRES-1:0]   load_data;
  logic                  op_valid;
  logic                  op_ready;
  logic [IDXW-1:0]       op_t;
  logic [IDXW-1:0]       op_c1;
  logic [IDXW-1:0]       op_c2;
  logic                  op_last;
  logic [1:0]            tof_a;
  logic [1:0]            tof_b;
  logic [1:0]            tof_c;
  logic [1:0]            tof_a_res;
  logic                  res_valid;
  logic [2*NWIRES-1:0]   res_data;
  logic                  res_ready;
  logic                  err;

  modport slave (
    input  load_valid, load_data, op_valid, op_t, op_c1, op_c2, op_last,
           tof_a_res, res_ready,
    output load_ready, op_ready, tof_a, tof_b, tof_c, res_valid, res_data, err
  );

  modport master (
    output load_valid, load_data, op_valid, op_t, op_c1, op_c2, op_last,
           tof_a_res, res_ready,
    input  load_ready, op_ready, tof_a, tof_b, tof_c, res_valid, res_data, err
  );
endinterface

// File: rtl/shared_toffoli_seq.sv
// ---------------------------------------------------------------------------
// shared_toffoli_seq
// Sequencer for one external 2-share masked Toffoli unit. Holds NWIRES masked
// wires, accepts a stream of ops wire[t] ^= wire[c1] & wire[c2], issues each
// op to the Toffoli unit and writes its result back into the wire state.
// Pipeline: accept -> s1 (drives tof_*) -> s2 (tof_a_res written to state).
// Read-after-write hazards against s1/s2 targets stall op_ready; there is no
// forwarding.
//
// Ports
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : shared_toffoli_seq_if.slave (load / op / tof / result / err)
//
// Build option
//   TOF_IDXCHK_EN : when defined, ops with an out-of-range index or with t
//                   equal to c1 or c2 are accepted as NOPs and set the sticky
//                   err flag. When undefined, err is 0, out-of-range reads
//                   return 0 and out-of-range writes are dropped.
// ---------------------------------------------------------------------------
module shared_toffoli_seq #(
  parameter int NWIRES = 8,
  parameter int IDXW   = 3
) (
  input logic               clk,
  input logic               rst,
  shared_toffoli_seq_if.slave bus
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } seqState_e;

  seqState_e           r_fsm;
  seqState_e           w_fsmNext;

  logic [1:0]          r_wire [NWIRES];
  logic                r_s1Valid;
  logic [IDXW-1:0]     r_s1T;
  logic                r_s2Valid;
  logic [IDXW-1:0]     r_s2T;
  logic [1:0]          r_tofA;
  logic [1:0]          r_tofB;
  logic [1:0]          r_tofC;

  logic                w_loadReady;
  logic                w_opReady;
  logic                w_resValid;
  logic                w_loadFire;
  logic                w_opAccept;
  logic                w_issue;
  logic                w_hazard;
  logic [1:0]          w_aSh;
  logic [1:0]          w_bSh;
  logic [1:0]          w_cSh;
  logic [2*NWIRES-1:0] w_resData;

  // An offered op must wait while any of its indices matches a target that
  // is still in flight, since the state has not been updated yet.
  always_comb begin
    w_hazard = 1'b0;
    if (r_s1Valid && (bus.op_t == r_s1T || bus.op_c1 == r_s1T || bus.op_c2 == r_s1T))
      w_hazard = 1'b1;
    if (r_s2Valid && (bus.op_t == r_s2T || bus.op_c1 == r_s2T || bus.op_c2 == r_s2T))
      w_hazard = 1'b1;
  end

  // Share mux from state; an index with no matching wire reads as 0.
  always_comb begin
    w_aSh = 2'b00;
    w_bSh = 2'b00;
    w_cSh = 2'b00;
    for (int i = 0; i < NWIRES; i++) begin
      if (bus.op_t  == IDXW'(i)) w_aSh = r_wire[i];
      if (bus.op_c1 == IDXW'(i)) w_bSh = r_wire[i];
      if (bus.op_c2 == IDXW'(i)) w_cSh = r_wire[i];
    end
  end

  // Next-state and handshake decode.
  always_comb begin
    w_fsmNext   = r_fsm;
    w_loadReady = 1'b0;
    w_opReady   = 1'b0;
    w_resValid  = 1'b0;
    case (r_fsm)
      StIdle: begin
        w_loadReady = 1'b1;
        if (bus.load_valid) w_fsmNext = StRun;
      end
      StRun: begin
        w_opReady = !w_hazard;
        if (bus.op_valid && !w_hazard && bus.op_last) w_fsmNext = StDrain;
      end
      StDrain: begin
        // s2 always retires in the current cycle, so once s1 is empty the
        // last write lands on this edge and DONE can show the final state.
        if (!r_s1Valid) w_fsmNext = StDone;
      end
      StDone: begin
        w_resValid = 1'b1;
        if (bus.res_ready) w_fsmNext = StIdle;
      end
      default: w_fsmNext = StIdle;
    endcase
    w_loadFire = w_loadReady && bus.load_valid;
    w_opAccept = w_opReady && bus.op_valid;
  end

`ifdef TOF_IDXCHK_EN
  logic w_illegal;
  logic r_err;

  function automatic logic idxInRange(input logic [IDXW-1:0] idx);
    idxInRange = 1'b0;
    for (int i = 0; i < NWIRES; i++)
      if (idx == IDXW'(i)) idxInRange = 1'b1;
  endfunction

  // Illegal ops still consume their handshake but never reach the unit.
  always_comb begin
    w_illegal = !idxInRange(bus.op_t) || !idxInRange(bus.op_c1) ||
                !idxInRange(bus.op_c2) || (bus.op_t == bus.op_c1) ||
                (bus.op_t == bus.op_c2);
    w_issue   = w_opAccept && !w_illegal;
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst)
      r_err <= 1'b0;
    else if (w_opAccept && w_illegal)
      r_err <= 1'b1;
  end

  assign bus.err = r_err;
`else
  assign w_issue = w_opAccept;
  assign bus.err = 1'b0;
`endif

  // State register of the sequencer FSM.
  always_ff @(posedge clk) begin
    if (rst)
      r_fsm <= StIdle;
    else
      r_fsm <= w_fsmNext;
  end

  // Issue (s1) and write-back (s2) stages. The tof_* registers are only
  // reloaded on issue; they hold their last value otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1Valid <= 1'b0;
      r_s1T     <= '0;
      r_s2Valid <= 1'b0;
      r_s2T     <= '0;
      r_tofA    <= 2'b00;
      r_tofB    <= 2'b00;
      r_tofC    <= 2'b00;
    end else begin
      r_s1Valid <= w_issue;
      if (w_issue) begin
        r_s1T  <= bus.op_t;
        r_tofA <= w_aSh;
        r_tofB <= w_bSh;
        r_tofC <= w_cSh;
      end
      r_s2Valid <= r_s1Valid;
      r_s2T     <= r_s1T;
    end
  end

  // Wire state: loaded in IDLE, updated from the Toffoli result in s2.
  // Load and write-back never coincide because IDLE implies an empty pipe.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NWIRES; i++) r_wire[i] <= 2'b00;
    end else if (w_loadFire) begin
      for (int i = 0; i < NWIRES; i++)
        r_wire[i] <= {bus.load_data[NWIRES+i], bus.load_data[i]};
    end else if (r_s2Valid) begin
      for (int i = 0; i < NWIRES; i++)
        if (r_s2T == IDXW'(i)) r_wire[i] <= bus.tof_a_res;
    end
  end

  // Result is presented only in DONE and reads as 0 elsewhere.
  always_comb begin
    w_resData = '0;
    if (r_fsm == StDone) begin
      for (int i = 0; i < NWIRES; i++) begin
        w_resData[i]        = r_wire[i][0];
        w_resData[NWIRES+i] = r_wire[i][1];
      end
    end
  end

  assign bus.load_ready = w_loadReady;
  assign bus.op_ready   = w_opReady;
  assign bus.res_valid  = w_resValid;
  assign bus.res_data   = w_resData;
  assign bus.tof_a      = r_tofA;
  assign bus.tof_b      = r_tofB;
  assign bus.tof_c      = r_tofC;

endmodule

// File: tb/tb_shared_toffoli_seq.sv
// ---------------------------------------------------------------------------
// tb_shared_toffoli_seq
// Directed bench for shared_toffoli_seq with a registered reference model of
// the 2-share Toffoli unit: res share0 = a0 ^ (b0^b1)&(c0^c1), res share1 = a1.
// Expected results below are hand-computed from that model.
// ---------------------------------------------------------------------------
module tb_shared_toffoli_seq;

  logic clk;
  logic rst;
  int   passCount;
  int   checkCount;

  shared_toffoli_seq_if #(.NWIRES(8), .IDXW(3)) bus ();

  shared_toffoli_seq #(.NWIRES(8), .IDXW(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Toffoli unit model: result valid one cycle after its inputs.
  always @(posedge clk) begin
    bus.tof_a_res[0] <= bus.tof_a[0] ^ (bus.tof_b[0] & bus.tof_c[0]) ^
                        (bus.tof_b[0] & bus.tof_c[1]) ^ (bus.tof_b[1] & bus.tof_c[0]) ^
                        (bus.tof_b[1] & bus.tof_c[1]);
    bus.tof_a_res[1] <= bus.tof_a[1];
  end

  // Watchdog so a stuck run still ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic doReset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic loadState(input logic [15:0] data);
    bus.load_data  = data;
    bus.load_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.load_valid = 1'b0;
  endtask

  // Offers an op until accepted; stalls = cycles op_ready was low, -1 on timeout.
  task automatic applyStimulus(input logic [2:0] t, input logic [2:0] c1,
                               input logic [2:0] c2, input logic last,
                               output int stalls);
    logic rdy;
    bus.op_t     = t;
    bus.op_c1    = c1;
    bus.op_c2    = c2;
    bus.op_last  = last;
    bus.op_valid = 1'b1;
    stalls = -1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      rdy = bus.op_ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        stalls = n;
        break;
      end
    end
    bus.op_valid = 1'b0;
    bus.op_last  = 1'b0;
  endtask

  // Cycles from just after acceptance until res_valid; -1 on timeout.
  task automatic waitResult(output int n);
    n = -1;
    for (int i = 0; i < 20; i++) begin
      if (bus.res_valid) begin
        n = i;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic finishResult();
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.res_ready = 1'b0;
  endtask

  task automatic test_reset();
    doReset();
    checkCount++;
    if (bus.load_ready !== 1'b1) $display("[TB] FAIL reset_load_ready: got %b expected 1", bus.load_ready);
    else passCount++;
    checkCount++;
    if (bus.op_ready !== 1'b0) $display("[TB] FAIL reset_op_ready: got %b expected 0", bus.op_ready);
    else passCount++;
    checkCount++;
    if ({bus.tof_a, bus.tof_b, bus.tof_c} !== 6'b0) $display("[TB] FAIL reset_tof: got %b expected 000000", {bus.tof_a, bus.tof_b, bus.tof_c});
    else passCount++;
    checkCount++;
    if (bus.res_valid !== 1'b0) $display("[TB] FAIL reset_res_valid: got %b expected 0", bus.res_valid);
    else passCount++;
    checkCount++;
    if (bus.res_data !== 16'h0000) $display("[TB] FAIL reset_res_data: got %h expected 0000", bus.res_data);
    else passCount++;
    checkCount++;
    if (bus.err !== 1'b0) $display("[TB] FAIL reset_err: got %b expected 0", bus.err);
    else passCount++;
  endtask

  // wire0 = 1/0, wire1 = 0/1, wire2 = 1/1; wire2 ^= wire0 & wire1 -> 0/1.
  task automatic test_single_op();
    int st;
    int n;
    doReset();
    loadState(16'h0605);
    checkCount++;
    if (bus.op_ready !== 1'b1) $display("[TB] FAIL single_run_ready: got %b expected 1", bus.op_ready);
    else passCount++;
    applyStimulus(3'd2, 3'd0, 3'd1, 1'b1, st);
    checkCount++;
    if (st !== 0) $display("[TB] FAIL single_stalls: got %0d expected 0", st);
    else passCount++;
    checkCount++;
    if ({bus.tof_a, bus.tof_b, bus.tof_c} !== 6'b11_01_10) $display("[TB] FAIL single_tof_issue: got %b expected 110110", {bus.tof_a, bus.tof_b, bus.tof_c});
    else passCount++;
    waitResult(n);
    checkCount++;
    if (n !== 2) $display("[TB] FAIL single_latency: got %0d expected 2", n);
    else passCount++;
    checkCount++;
    if (bus.res_data !== 16'h0601) $display("[TB] FAIL single_res_data: got %h expected 0601", bus.res_data);
    else passCount++;
    checkCount++;
    if ((bus.res_data[2] ^ bus.res_data[10]) !== 1'b1) $display("[TB] FAIL single_wire2_value: got %b expected 1", bus.res_data[2] ^ bus.res_data[10]);
    else passCount++;
    finishResult();
    checkCount++;
    if ({bus.load_ready, bus.res_valid} !== 2'b10) $display("[TB] FAIL single_back_idle: got %b expected 10", {bus.load_ready, bus.res_valid});
    else passCount++;
  endtask

  // wire3 ^= wire2(new) & wire0 must wait two cycles for wire2's write.
  task automatic test_raw_stall();
    int st;
    int n;
    doReset();
    loadState(16'h0605);
    applyStimulus(3'd2, 3'd0, 3'd1, 1'b0, st);
    checkCount++;
    if (st !== 0) $display("[TB] FAIL raw_first_stalls: got %0d expected 0", st);
    else passCount++;
    applyStimulus(3'd3, 3'd2, 3'd0, 1'b1, st);
    checkCount++;
    if (st !== 2) $display("[TB] FAIL raw_second_stalls: got %0d expected 2", st);
    else passCount++;
    waitResult(n);
    checkCount++;
    if (n !== 2) $display("[TB] FAIL raw_latency: got %0d expected 2", n);
    else passCount++;
    checkCount++;
    if (bus.res_data !== 16'h0609) $display("[TB] FAIL raw_res_data: got %h expected 0609", bus.res_data);
    else passCount++;
    finishResult();
  endtask

  // Independent ops t=4 and t=5 go out on consecutive cycles.
  task automatic test_back_to_back();
    int st;
    int n;
    doReset();
    loadState(16'h0609);
    applyStimulus(3'd4, 3'd0, 3'd1, 1'b0, st);
    checkCount++;
    if (st !== 0) $display("[TB] FAIL b2b_first_stalls: got %0d expected 0", st);
    else passCount++;
    applyStimulus(3'd5, 3'd2, 3'd3, 1'b1, st);
    checkCount++;
    if (st !== 0) $display("[TB] FAIL b2b_second_stalls: got %0d expected 0", st);
    else passCount++;
    waitResult(n);
    checkCount++;
    if (n !== 2) $display("[TB] FAIL b2b_latency: got %0d expected 2", n);
    else passCount++;
    checkCount++;
    if (bus.res_data !== 16'h0639) $display("[TB] FAIL b2b_res_data: got %h expected 0639", bus.res_data);
    else passCount++;
    finishResult();
  endtask

  // Illegal op t=1, c1=1, c2=0 followed by a legal op on wire2.
  task automatic test_illegal();
    int st;
    int n;
    doReset();
    loadState(16'h0605);
    applyStimulus(3'd1, 3'd1, 3'd0, 1'b0, st);
    checkCount++;
    if (st !== 0) $display("[TB] FAIL illegal_stalls: got %0d expected 0", st);
    else passCount++;
`ifdef TOF_IDXCHK_EN
    checkCount++;
    if (bus.err !== 1'b1) $display("[TB] FAIL illegal_err_set: got %b expected 1", bus.err);
    else passCount++;
    applyStimulus(3'd2, 3'd0, 3'd1, 1'b1, st);
    checkCount++;
    if (st !== 0) $display("[TB] FAIL illegal_next_stalls: got %0d expected 0", st);
    else passCount++;
    waitResult(n);
    checkCount++;
    if (bus.res_data !== 16'h0601) $display("[TB] FAIL illegal_res_data: got %h expected 0601", bus.res_data);
    else passCount++;
    checkCount++;
    if (bus.err !== 1'b1) $display("[TB] FAIL illegal_err_sticky: got %b expected 1", bus.err);
    else passCount++;
`else
    checkCount++;
    if (bus.err !== 1'b0) $display("[TB] FAIL nochk_err: got %b expected 0", bus.err);
    else passCount++;
    applyStimulus(3'd2, 3'd0, 3'd1, 1'b1, st);
    checkCount++;
    if (st !== 2) $display("[TB] FAIL nochk_next_stalls: got %0d expected 2", st);
    else passCount++;
    waitResult(n);
    checkCount++;
    if (bus.res_data !== 16'h0607) $display("[TB] FAIL nochk_res_data: got %h expected 0607", bus.res_data);
    else passCount++;
`endif
    checkCount++;
    if (n !== 2) $display("[TB] FAIL illegal_latency: got %0d expected 2", n);
    else passCount++;
    finishResult();
  endtask

  // Reset one cycle after acceptance; the pending wire2 write must vanish.
  task automatic test_reset_midrun();
    int st;
    int n;
    doReset();
    loadState(16'h0605);
    applyStimulus(3'd2, 3'd0, 3'd1, 1'b0, st);
    checkCount++;
    if (st !== 0) $display("[TB] FAIL midrst_stalls: got %0d expected 0", st);
    else passCount++;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkCount++;
    if ({bus.load_ready, bus.op_ready, bus.res_valid} !== 3'b100) $display("[TB] FAIL midrst_handshake: got %b expected 100", {bus.load_ready, bus.op_ready, bus.res_valid});
    else passCount++;
    checkCount++;
    if (bus.res_data !== 16'h0000) $display("[TB] FAIL midrst_res_data: got %h expected 0000", bus.res_data);
    else passCount++;
    checkCount++;
    if (bus.tof_a !== 2'b00) $display("[TB] FAIL midrst_tof_a: got %b expected 00", bus.tof_a);
    else passCount++;
    // Load lands on the edge where the discarded write would have landed.
    loadState(16'h0605);
    applyStimulus(3'd6, 3'd0, 3'd1, 1'b1, st);
    checkCount++;
    if (st !== 0) $display("[TB] FAIL midrst_next_stalls: got %0d expected 0", st);
    else passCount++;
    waitResult(n);
    checkCount++;
    if (bus.res_data !== 16'h0645) $display("[TB] FAIL midrst_res_data_after: got %h expected 0645", bus.res_data);
    else passCount++;
    finishResult();
  endtask

  // Hold res_ready low for 5 cycles in DONE, then release.
  task automatic test_backpressure();
    int st;
    int n;
    doReset();
    loadState(16'h0605);
    applyStimulus(3'd2, 3'd0, 3'd1, 1'b1, st);
    waitResult(n);
    checkCount++;
    if (n !== 2) $display("[TB] FAIL bp_latency: got %0d expected 2", n);
    else passCount++;
    for (int i = 0; i < 5; i++) begin
      checkCount++;
      if ({bus.res_valid, bus.load_ready, bus.res_data} !== {2'b10, 16'h0601})
        $display("[TB] FAIL bp_hold_%0d: got %b/%b/%h expected 1/0/0601", i, bus.res_valid, bus.load_ready, bus.res_data);
      else passCount++;
      @(posedge clk);
      #1;
    end
    finishResult();
    checkCount++;
    if ({bus.load_ready, bus.res_valid} !== 2'b10) $display("[TB] FAIL bp_release: got %b expected 10", {bus.load_ready, bus.res_valid});
    else passCount++;
  endtask

  // Runs every scenario in order and prints the summary.
  initial begin
    passCount      = 0;
    checkCount     = 0;
    rst            = 1'b1;
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    bus.op_valid   = 1'b0;
    bus.op_t       = '0;
    bus.op_c1      = '0;
    bus.op_c2      = '0;
    bus.op_last    = 1'b0;
    bus.res_ready  = 1'b0;
    $display("[TB] starting shared_toffoli_seq bench");
    test_reset();
    test_single_op();
    test_raw_stall();
    test_back_to_back();
    test_illegal();
    test_reset_midrun();
    test_backpressure();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/shared_toffoli_seq.md
# shared_toffoli_seq

Sequencer for the 2-share masked Toffoli unit. It holds a masked wire state of `NWIRES` bits, with two shares per bit, and accepts a stream of Toffoli operations `wire[t] ^= wire[c1] & wire[c2]`. It issues each operation to one external shared Toffoli instance and writes the result back into the state. Operations are pipelined at up to one per cycle, with read-after-write hazard stalls. This block sits between the masked-permutation top level and the shared Toffoli datapath.

## Interface

**Parameters**
- `NWIRES`, default 8: number of masked wires.
- `IDXW`, default 3: wire-index width; must satisfy `2**IDXW >= NWIRES`.

**Ports**
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `load_valid` in 1: initial-state load request.
- `load_ready` out 1: high in IDLE only.
- `load_data` in 2*NWIRES: share0 of wire i at `[i]`, share1 at `[NWIRES+i]`.
- `op_valid` in 1: operation offered.
- `op_ready` out 1: operation accepted when both valid and ready are high.
- `op_t`, `op_c1`, `op_c2` in IDXW each: target, control 1, control 2.
- `op_last` in 1: marks the final operation of the program.
- `tof_a`, `tof_b`, `tof_c` out 2 each: shares of target, control 1, control 2 to the Toffoli unit.
- `tof_a_res` in 2: result shares from the Toffoli unit, valid one cycle after its inputs.
- `res_valid` out 1: final state available.
- `res_data` out 2*NWIRES: final state, same layout as `load_data`.
- `res_ready` in 1: result consumed.
- `err` out 1: sticky illegal-operation flag (see Configuration).

## Operation

**States:** IDLE → RUN → DRAIN → DONE → IDLE.

**IDLE**
- `load_ready` = 1.
- A load handshake copies `load_data` into the state register and moves to RUN.

**RUN**
- `op_ready` = !hazard.
- On an accepted op, the shares of `t`, `c1`, `c2` are muxed from the state into issue registers `s1`. These registers drive `tof_*` in the next cycle.
- The op's target index and a valid bit pipeline through `s1` and then `s2`.
- In the `s2` cycle, `tof_a_res` is written into `state[t]`.
- Accepting an op with `op_last` = 1 moves to DRAIN.

**Hazard**
- A hazard exists when the offered op's `t`, `c1` or `c2` equals the target of a valid op in `s1` or `s2`.
- No forwarding. The offered op waits until the conflicting write has landed.

**DRAIN**
- `op_ready` = 0.
- Moves to DONE once `s1` and `s2` are both empty.

**DONE**
- `res_valid` = 1 and `res_data` = state, held stable until `res_ready`.
- On `res_ready`, moves to IDLE and clears `res_valid`.

**Index rules**
- Indices ≥ `NWIRES`, or `t` equal to `c1` or `c2`, are illegal (handling per Configuration).
- `c1 == c2` is legal (AND with itself).

**Share handling**
- Shares are never combined or recombined inside this block.
- `tof_*` are driven only from registers. There are no combinational paths from the state mux to the Toffoli unit.

**Reset**
- Applies in any state, mid-operation included.
- Next state is IDLE; state register, `s1`, `s2`, `err` and `res_valid` all clear to 0.
- Outputs after reset: `load_ready` = 1, `op_ready` = 0, `tof_*` = 0, `res_data` = 0.
- In-flight ops are discarded.

## Timing

- An op accepted in cycle k:
  - drives `tof_*` in cycle k+1;
  - `tof_a_res` is sampled in k+2;
  - `state[t]` is updated at the end of k+2.
- A dependent op can be accepted no earlier than k+3 (at most 2 stall cycles).
- Independent ops are accepted back-to-back, 1 per cycle.
- After the last op is accepted in cycle k, `res_valid` rises in cycle k+3.
- `load_valid` and `op_valid` are ignored in states where the corresponding ready is low.
- `op_valid` may drop without the op being accepted; nothing is latched.

## Configuration

**`TOF_IDXCHK_EN`**
- **Defined:**
  - Illegal ops are still accepted (one `op_ready` cycle) but are not issued; they are converted to a NOP.
  - `err` is set and stays set until reset.
  - An illegal op carrying `op_last` still moves to DRAIN.
- **Undefined:**
  - No checking; `err` is tied to 0.
  - Out-of-range indices read share value 0 and their writes are dropped.
  - `t == c` gives whatever the Toffoli unit computes.

## Test plan

- **Single op:** load wire0=1 (shares 1/0), wire1=1 (0/1), wire2=0 (1/1); op t=2, c1=0, c2=1, last. Expected: `res_valid` 3 cycles after acceptance; wire2 share XOR = 1; all other wires unchanged.
- **RAW stall:** ops t=2,c=(0,1) then t=3,c=(2,0). Expected: `op_ready` low for exactly 2 cycles before the second op; wire3 reflects the updated wire2.
- **Back-to-back:** ops t=4,c=(0,1) and t=5,c=(2,3) offered on consecutive cycles. Expected: accepted in consecutive cycles with no stall.
- **Illegal op (`TOF_IDXCHK_EN`):** op t=1, c1=1, c2=0. Expected: `err` = 1 the next cycle; state unchanged; following legal ops still execute.
- **Reset mid-run:** assert `rst` one cycle after an op is accepted. Expected: next cycle is IDLE, `load_ready` = 1, `res_data` = 0, no write to the state.
- **Result backpressure:** hold `res_ready` = 0 for 5 cycles in DONE. Expected: `res_valid` and `res_data` stay stable; IDLE is entered the cycle after `res_ready` = 1.
